dh_link_arbiter: RTL and testbench

- Sequences the single shared drone↔CC message link between two drones.
- Replaces the static priority mux in front of the CC with a round-robin, transaction-holding arbiter.
- Grants one drone, forwards its 2N-bit message to the CC, and waits for the CC's N-bit reply. It then routes the reply back to the granted drone only and releases the link.
- A timeout recovers the link if the CC never answers.

---
 rtl/dh_link_pkg.sv | 22 ++
 rtl/dh_link_arbiter_rr_arbiter2.sv | 18 +
 rtl/dh_link_arbiter.sv | 135 +++++++++++++
 tb/tb_dh_link_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dh_link_pkg.sv
// Shared types and constants for the drone/CC link arbiter.
package dh_link_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StWaitCc,
    StDone
  } state_e;

  localparam int unsigned DRONE1_IDX = 0;
  localparam int unsigned DRONE2_IDX = 1;

  // Counter only has to reach TIMEOUT-1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout <= 1) ? 1 : $clog2(timeout);
  endfunction

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W_DEFAULT   = cnt_width(TIMEOUT_DEFAULT);

endpackage

// File: rtl/dh_link_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker; 'last' is the index of the drone served last.
module rr_arbiter2
  import dh_link_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = 2'b00;
      pick[last ? DRONE1_IDX : DRONE2_IDX] = 1'b1;
    end
  end

endmodule

// File: rtl/dh_link_arbiter.sv
// Round-robin, transaction-holding arbiter for the shared drone<->CC message link.
module dh_link_arbiter
  import dh_link_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [1:0]     req,
  input  logic [2*N-1:0] mess_in0,
  input  logic [2*N-1:0] mess_in1,
  input  logic           cc_rdy,
  input  logic [N-1:0]   mess_cc,
  output logic [1:0]     grant,
  output logic           drone_rdy_cc,
  output logic [2*N-1:0] mess_to_cc,
  output logic [1:0]     received,
  output logic [N-1:0]   mess_to_drone0,
  output logic [N-1:0]   mess_to_drone1,
  output logic           busy,
  output logic           timeout_err
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT - 1);

  state_e         r_state_q, w_state_d;
  logic [CntW-1:0] r_cnt_q, w_cnt_d;
  logic           r_last_q, w_last_d;
  logic [1:0]     r_grant_q, w_grant_d;
  logic           r_rdy_q, w_rdy_d;
  logic [2*N-1:0] r_msg_q, w_msg_d;
  logic [1:0]     r_rcv_q, w_rcv_d;
  logic [N-1:0]   r_m0_q, w_m0_d;
  logic [N-1:0]   r_m1_q, w_m1_d;
  logic           r_busy_q, w_busy_d;
  logic           r_tout_q, w_tout_d;
  logic [1:0]     w_pick;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (r_last_q),
    .pick (w_pick)
  );

  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_last_d  = r_last_q;
    w_grant_d = r_grant_q;
    w_msg_d   = r_msg_q;
    w_m0_d    = r_m0_q;
    w_m1_d    = r_m1_q;
    w_rdy_d   = 1'b0;
    w_rcv_d   = 2'b00;
    w_tout_d  = 1'b0;
    unique case (r_state_q)
      StIdle: begin
        if (req != 2'b00) begin
          w_state_d = StFwd;
          w_grant_d = w_pick;
          w_rdy_d   = 1'b1;
          w_msg_d   = w_pick[DRONE2_IDX] ? mess_in1 : mess_in0;
        end
      end
      StFwd: begin
        w_state_d = StWaitCc;
        w_cnt_d   = '0;
      end
      StWaitCc: begin
        // A reply on the terminal count still completes the transaction.
        if (cc_rdy) begin
          w_state_d = StDone;
          w_rcv_d   = r_grant_q;
          if (r_grant_q[DRONE2_IDX]) w_m1_d = mess_cc;
          else                       w_m0_d = mess_cc;
        end else if (r_cnt_q == TermCnt) begin
          w_state_d = StIdle;
          w_tout_d  = 1'b1;
          w_grant_d = 2'b00;
          w_last_d  = r_grant_q[DRONE2_IDX];
        end else begin
          w_cnt_d = r_cnt_q + CntW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_grant_d = 2'b00;
        w_last_d  = r_grant_q[DRONE2_IDX];
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= StIdle;
      r_cnt_q   <= '0;
      r_last_q  <= 1'b1;
      r_grant_q <= 2'b00;
      r_rdy_q   <= 1'b0;
      r_msg_q   <= '0;
      r_rcv_q   <= 2'b00;
      r_m0_q    <= '0;
      r_m1_q    <= '0;
      r_busy_q  <= 1'b0;
      r_tout_q  <= 1'b0;
    end else if (ena) begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      r_last_q  <= w_last_d;
      r_grant_q <= w_grant_d;
      r_rdy_q   <= w_rdy_d;
      r_msg_q   <= w_msg_d;
      r_rcv_q   <= w_rcv_d;
      r_m0_q    <= w_m0_d;
      r_m1_q    <= w_m1_d;
      r_busy_q  <= w_busy_d;
      r_tout_q  <= w_tout_d;
    end
  end

  assign grant          = r_grant_q;
  assign drone_rdy_cc   = r_rdy_q;
  assign mess_to_cc     = r_msg_q;
  assign received       = r_rcv_q;
  assign mess_to_drone0 = r_m0_q;
  assign mess_to_drone1 = r_m1_q;
  assign busy           = r_busy_q;
  assign timeout_err    = r_tout_q;

endmodule

// File: tb/tb_dh_link_arbiter.sv
// Directed bench for dh_link_arbiter, built with a short timeout of 4 cycles.
module tb_dh_link_arbiter;

  localparam int unsigned N = 8;

  logic           clk, rst, ena, cc_rdy;
  logic [1:0]     req;
  logic [2*N-1:0] mess_in0, mess_in1;
  logic [N-1:0]   mess_cc;
  logic [1:0]     grant, received;
  logic           drone_rdy_cc, busy, timeout_err;
  logic [2*N-1:0] mess_to_cc;
  logic [N-1:0]   mess_to_drone0, mess_to_drone1;

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] exp_m0, exp_m1;
  logic [1:0]   exp_g;

  dh_link_arbiter #(.N(N), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .req            (req),
    .mess_in0       (mess_in0),
    .mess_in1       (mess_in1),
    .cc_rdy         (cc_rdy),
    .mess_cc        (mess_cc),
    .grant          (grant),
    .drone_rdy_cc   (drone_rdy_cc),
    .mess_to_cc     (mess_to_cc),
    .received       (received),
    .mess_to_drone0 (mess_to_drone0),
    .mess_to_drone1 (mess_to_drone1),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"}, 32'(grant), 0);
    chk({tag, ".rdy"}, 32'(drone_rdy_cc), 0);
    chk({tag, ".mcc"}, 32'(mess_to_cc), 0);
    chk({tag, ".rcv"}, 32'(received), 0);
    chk({tag, ".m0"}, 32'(mess_to_drone0), 0);
    chk({tag, ".m1"}, 32'(mess_to_drone1), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".tout"}, 32'(timeout_err), 0);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; req = 2'b00; cc_rdy = 1'b0;
    mess_in0 = '0; mess_in1 = '0; mess_cc = '0;
    #3;
    chk_all_zero("reset");
    step();
    rst = 1'b1;

    // Single request from drone1
    req = 2'b01; mess_in0 = 16'hA55A; mess_in1 = 16'h1234;
    step();
    chk("t1.grant", 32'(grant), 32'h1);
    chk("t1.rdy", 32'(drone_rdy_cc), 1);
    chk("t1.mcc", 32'(mess_to_cc), 32'hA55A);
    chk("t1.busy", 32'(busy), 1);
    req = 2'b00;
    step();
    chk("t1.rdy_low", 32'(drone_rdy_cc), 0);
    cc_rdy = 1'b1; mess_cc = 8'h3C;
    step();
    cc_rdy = 1'b0;
    chk("t1.rcv", 32'(received), 32'h1);
    chk("t1.m0", 32'(mess_to_drone0), 32'h3C);
    chk("t1.m1", 32'(mess_to_drone1), 32'h00);
    step();
    chk("t1.rcv_low", 32'(received), 0);
    chk("t1.grant_idle", 32'(grant), 0);
    chk("t1.busy_idle", 32'(busy), 0);
    chk("t1.mcc_hold", 32'(mess_to_cc), 32'hA55A);
    exp_m0 = 8'h3C; exp_m1 = 8'h00;

    // Both drones requesting continuously: drone1 was last, so drone2 first
    req = 2'b11;
    exp_g = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr.grant", 32'(grant), 32'(exp_g));
      chk("rr.mcc", 32'(mess_to_cc), exp_g[1] ? 32'h1234 : 32'hA55A);
      step();
      step();
      cc_rdy = 1'b1; mess_cc = 8'(8'h10 + i);
      step();
      cc_rdy = 1'b0;
      if (exp_g[1]) exp_m1 = 8'(8'h10 + i);
      else          exp_m0 = 8'(8'h10 + i);
      chk("rr.rcv", 32'(received), 32'(exp_g));
      chk("rr.m0", 32'(mess_to_drone0), 32'(exp_m0));
      chk("rr.m1", 32'(mess_to_drone1), 32'(exp_m1));
      step();
      chk("rr.release", 32'(grant), 0);
      exp_g = ~exp_g;
    end
    req = 2'b00;
    step();

    // Timeout on drone2
    req = 2'b10;
    step();
    chk("to.grant", 32'(grant), 32'h2);
    req = 2'b00;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to.early", 32'(timeout_err), 0);
      chk("to.held", 32'(grant), 32'h2);
    end
    step();
    chk("to.pulse", 32'(timeout_err), 1);
    chk("to.grant0", 32'(grant), 0);
    chk("to.busy0", 32'(busy), 0);
    chk("to.rcv0", 32'(received), 0);

    // Stray cc_rdy while idle and during FWD
    cc_rdy = 1'b1; mess_cc = 8'hEE;
    step();
    chk("stray.tout_low", 32'(timeout_err), 0);
    chk("stray.idle_rcv", 32'(received), 0);
    req = 2'b11;
    step();
    chk("to.next_grant", 32'(grant), 32'h1);
    chk("stray.fwd_rcv", 32'(received), 0);
    req = 2'b00;
    step();
    cc_rdy = 1'b0;
    chk("stray.wait_rcv", 32'(received), 0);
    chk("stray.m0", 32'(mess_to_drone0), 32'(exp_m0));
    chk("stray.m1", 32'(mess_to_drone1), 32'(exp_m1));

    // Enable stall in WAIT_CC
    step();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall.tout", 32'(timeout_err), 0);
      chk("stall.grant", 32'(grant), 32'h1);
    end
    ena = 1'b1;
    step();
    step();
    chk("stall.no_tout", 32'(timeout_err), 0);
    // Reply lands on the terminal-count edge and must win
    cc_rdy = 1'b1; mess_cc = 8'h5A;
    step();
    cc_rdy = 1'b0;
    exp_m0 = 8'h5A;
    chk("stall.rcv", 32'(received), 32'h1);
    chk("stall.m0", 32'(mess_to_drone0), 32'(exp_m0));
    chk("stall.tout_tie", 32'(timeout_err), 0);
    step();

    // Asynchronous reset mid-transaction
    req = 2'b01;
    step();
    req = 2'b00;
    step();
    chk("rst.pre_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("rst.async");
    #1 rst = 1'b1;
    req = 2'b11;
    step();
    chk("rst.first", 32'(grant), 32'h1);
    chk("rst.rdy", 32'(drone_rdy_cc), 1);
    req = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
